// File: rtl/phys_reg_free_list_if.sv
// Rename/commit side bundle for the physical register free list.
//
// Signals:
//   alloc_req0_i / alloc_req1_i   rename slots asking for a destination tag
//   alloc_ready_o                 every asserted request can be satisfied
//   alloc_tag0_o / alloc_tag1_o   tags offered to rename slots 0 and 1
//   free0_i / free1_i             commit slots returning a tag
//   free_tag0_i / free_tag1_i     tags being returned
//   free_count_o                  number of tags currently held
//   empty_o                       no tags held
//   err_o                         sticky overflow flag
//
// Modports:
//   master  rename + commit logic (drives requests and frees)
//   slave   the free list itself
interface phys_reg_free_list_if #(
   parameter int NUM_P_REGS = 64,
   parameter int NUM_A_REGS = 32
);
   localparam int TW  = $clog2(NUM_P_REGS);
   localparam int CAP = NUM_P_REGS - NUM_A_REGS;
   localparam int CW  = $clog2(CAP + 1);

   logic          alloc_req0_i;
   logic          alloc_req1_i;
   logic          alloc_ready_o;
   logic [TW-1:0] alloc_tag0_o;
   logic [TW-1:0] alloc_tag1_o;
   logic          free0_i;
   logic          free1_i;
   logic [TW-1:0] free_tag0_i;
   logic [TW-1:0] free_tag1_i;
   logic [CW-1:0] free_count_o;
   logic          empty_o;
   logic          err_o;

   modport master (
      output alloc_req0_i,
      output alloc_req1_i,
      input  alloc_ready_o,
      input  alloc_tag0_o,
      input  alloc_tag1_o,
      output free0_i,
      output free1_i,
      output free_tag0_i,
      output free_tag1_i,
      input  free_count_o,
      input  empty_o,
      input  err_o
   );

   modport slave (
      input  alloc_req0_i,
      input  alloc_req1_i,
      output alloc_ready_o,
      output alloc_tag0_o,
      output alloc_tag1_o,
      input  free0_i,
      input  free1_i,
      input  free_tag0_i,
      input  free_tag1_i,
      output free_count_o,
      output empty_o,
      output err_o
   );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags for the rename stage.
// Offers up to two tags per cycle (combinational peek at head) and takes
// back up to two tags per cycle from commit. Tag 0 is the hardwired-zero
// register: it is never held, and returning it is silently ignored.
//
// Ports:
//   clk_i   clock, all state updates on posedge
//   rst_i   asynchronous active-high reset; entries reload with
//           NUM_A_REGS .. NUM_P_REGS-1, count = CAP, err cleared
//   bus     phys_reg_free_list_if slave modport (alloc/free handshake,
//           count, empty and sticky error status)
module phys_reg_free_list #(
   parameter int NUM_P_REGS = 64,
   parameter int NUM_A_REGS = 32
) (
   input logic                 clk_i,
   input logic                 rst_i,
   phys_reg_free_list_if.slave bus
);
   localparam int TW  = $clog2(NUM_P_REGS);
   localparam int CAP = NUM_P_REGS - NUM_A_REGS;
   localparam int CW  = $clog2(CAP + 1);
   localparam int PW  = (CAP > 1) ? $clog2(CAP) : 1;

   typedef logic [TW-1:0] tag_t;
   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   // Pointer advance by 0..2 with wrap at CAP; CAP need not be a power of two.
   function automatic ptr_t ptr_add(input ptr_t p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= CAP) s = s - CAP;
      return ptr_t'(s);
   endfunction

   tag_t entry [CAP];
   ptr_t head;
   ptr_t tail;
   cnt_t count;
   logic err;

   cnt_t n_req;
   logic ready;
   cnt_t granted;
   cnt_t cnt_after_alloc;
   cnt_t cnt_mid;
   cnt_t count_next;
   logic want0;
   logic want1;
   logic acc0;
   logic acc1;
   logic overflow;
   ptr_t head_p1;
   ptr_t head_next;
   ptr_t tail_slot1;
   ptr_t tail_next;

   // Readiness looks only at the registered count, so a same-cycle free can
   // never fund a same-cycle allocation.
   assign n_req   = cnt_t'(bus.alloc_req0_i) + cnt_t'(bus.alloc_req1_i);
   assign ready   = (count >= n_req);
   assign granted = ready ? n_req : '0;

   assign cnt_after_alloc = count - granted;

   // Frees are accepted in slot order while space remains after this
   // cycle's allocation; anything beyond CAP is dropped and flagged.
   assign want0    = bus.free0_i && (bus.free_tag0_i != '0);
   assign want1    = bus.free1_i && (bus.free_tag1_i != '0);
   assign acc0     = want0 && (cnt_after_alloc < cnt_t'(CAP));
   assign cnt_mid  = cnt_after_alloc + cnt_t'(acc0);
   assign acc1     = want1 && (cnt_mid < cnt_t'(CAP));
   assign count_next = cnt_mid + cnt_t'(acc1);
   assign overflow = (want0 && !acc0) || (want1 && !acc1);

   assign head_p1    = ptr_add(head, 1);
   assign head_next  = ptr_add(head, int'(granted));
   assign tail_slot1 = ptr_add(tail, acc0 ? 1 : 0);
   assign tail_next  = ptr_add(tail, int'(acc0) + int'(acc1));

   // Slot 1 takes the second entry only when slot 0 consumes the first.
   assign bus.alloc_tag0_o  = entry[head];
   assign bus.alloc_tag1_o  = bus.alloc_req0_i ? entry[head_p1] : entry[head];
   assign bus.alloc_ready_o = ready;
   assign bus.free_count_o  = count;
   assign bus.empty_o       = (count == '0);
   assign bus.err_o         = err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < CAP; i++) begin
            entry[i] <= tag_t'(NUM_A_REGS + i);
         end
         head  <= '0;
         tail  <= '0;
         count <= cnt_t'(CAP);
         err   <= 1'b0;
      end else begin
         // Writes land only in slots outside the live window, so they never
         // disturb entries being offered at head this cycle.
         if (acc0) entry[tail] <= bus.free_tag0_i;
         if (acc1) entry[tail_slot1] <= bus.free_tag1_i;
         head  <= head_next;
         tail  <= tail_next;
         count <= count_next;
         if (overflow) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
   localparam int NP  = 64;
   localparam int NA  = 32;
   localparam int CAP = NP - NA;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   phys_reg_free_list_if #(.NUM_P_REGS(NP), .NUM_A_REGS(NA)) bus ();

   phys_reg_free_list #(.NUM_P_REGS(NP), .NUM_A_REGS(NA)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: the free tags in FIFO order plus the sticky error bit.
   int   fifo [$];
   int   exp_q [$];
   logic exp_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fifo.delete();
      exp_q.delete();
      for (int i = 0; i < CAP; i++) fifo.push_back(NA + i);
      exp_err = 1'b0;
   endtask

   task automatic set_inputs(input logic r0, input logic r1,
                             input logic f0, input logic [5:0] t0,
                             input logic f1, input logic [5:0] t1);
      bus.alloc_req0_i = r0;
      bus.alloc_req1_i = r1;
      bus.free0_i      = f0;
      bus.free_tag0_i  = t0;
      bus.free1_i      = f1;
      bus.free_tag1_i  = t1;
   endtask

   task automatic check_state(input string where);
      chk({where, "_count"}, 32'(bus.free_count_o), 32'(fifo.size()));
      chk({where, "_empty"}, 32'(bus.empty_o), 32'(fifo.size() == 0));
      chk({where, "_err"},   32'(bus.err_o), 32'(exp_err));
   endtask

   // One clock: drive at negedge, check offer/ready before posedge, advance
   // the model, then check registered state just after posedge.
   task automatic step(input logic r0, input logic r1,
                       input logic f0, input logic [5:0] t0,
                       input logic f1, input logic [5:0] t1);
      int  n;
      logic exp_rdy;
      @(negedge clk);
      set_inputs(r0, r1, f0, t0, f1, t1);
      #1;
      n = int'(r0) + int'(r1);
      exp_rdy = (fifo.size() >= n);
      chk("ready", 32'(bus.alloc_ready_o), 32'(exp_rdy));
      if (exp_rdy) begin
         if (r0) exp_q.push_back(fifo.pop_front());
         if (r1) exp_q.push_back(fifo.pop_front());
         if (r0) chk("tag0", 32'(bus.alloc_tag0_o), 32'(exp_q.pop_front()));
         if (r1) chk("tag1", 32'(bus.alloc_tag1_o), 32'(exp_q.pop_front()));
      end
      if (f0 && t0 != 6'd0) begin
         if (fifo.size() < CAP) fifo.push_back(int'(t0));
         else exp_err = 1'b1;
      end
      if (f1 && t1 != 6'd0) begin
         if (fifo.size() < CAP) fifo.push_back(int'(t1));
         else exp_err = 1'b1;
      end
      @(posedge clk);
      #1;
      check_state("post");
   endtask

   initial begin
      set_inputs(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state and offer peek under different request patterns.
      #1;
      check_state("reset");
      chk("reset_tag0", 32'(bus.alloc_tag0_o), 32'd32);
      chk("reset_tag1_noreq0", 32'(bus.alloc_tag1_o), 32'd32);
      bus.alloc_req0_i = 1'b1;
      bus.alloc_req1_i = 1'b1;
      #1;
      chk("reset_tag1_req0", 32'(bus.alloc_tag1_o), 32'd33);
      chk("reset_ready_both", 32'(bus.alloc_ready_o), 32'd1);
      bus.alloc_req0_i = 1'b0;
      #1;
      chk("reset_ready_req1", 32'(bus.alloc_ready_o), 32'd1);
      bus.alloc_req1_i = 1'b0;

      // Two-wide allocation for three cycles, then slot 1 alone.
      repeat (3) step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("after3_count", 32'(bus.free_count_o), 32'd26);
      step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);

      // Drain to one, then a blocked two-wide request with a same-cycle free.
      repeat (12) step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("drained_count", 32'(bus.free_count_o), 32'd1);
      step(1'b1, 1'b1, 1'b1, 6'd40, 1'b0, 6'd0);
      chk("blocked_count", 32'(bus.free_count_o), 32'd2);
      step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("empty_flag", 32'(bus.empty_o), 32'd1);
      step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);

      // Refill to 30, then a tag-0 free beside a real one.
      for (int i = 0; i < 15; i++)
         step(1'b0, 1'b0, 1'b1, 6'(2 * i + 1), 1'b1, 6'(2 * i + 2));
      step(1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 6'd45);
      chk("tag0_drop_count", 32'(bus.free_count_o), 32'd31);
      chk("tag0_drop_err", 32'(bus.err_o), 32'd0);

      // Fill, then overflow with no allocation.
      step(1'b0, 1'b0, 1'b1, 6'd46, 1'b0, 6'd0);
      step(1'b0, 1'b0, 1'b1, 6'd50, 1'b1, 6'd51);
      chk("ovf_count", 32'(bus.free_count_o), 32'd32);
      chk("ovf_err", 32'(bus.err_o), 32'd1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);

      // Wrap-around: two in, two out every cycle for 20 cycles.
      for (int k = 0; k < 20; k++)
         step(1'b1, 1'b1, 1'b1, 6'(1 + (2 * k) % 62), 1'b1, 6'(1 + (2 * k + 1) % 62));
      chk("wrap_err_sticky", 32'(bus.err_o), 32'd1);

      // Asynchronous reset in mid-cycle with traffic asserted.
      step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd7);
      @(negedge clk);
      set_inputs(1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 6'd10);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_state("async_rst");
      chk("async_rst_tag0", 32'(bus.alloc_tag0_o), 32'd32);
      chk("async_rst_tag1", 32'(bus.alloc_tag1_o), 32'd33);
      repeat (2) @(posedge clk);
      #1;
      check_state("rst_held");
      @(negedge clk);
      set_inputs(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      rst = 1'b0;

      step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      step(1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 6'd0);
      chk("final_count", 32'(bus.free_count_o), 32'd30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
